// File: rtl/gobou_ctrl_fc.sv
// -----------------------------------------------------------------------------
// gobou_ctrl_fc
// Control sequencer for a gobou fully-connected layer. On a req pulse in IDLE
// it latches the layer parameters, then for every group of LANES output
// neurons it streams n_in ctrl beats (start/valid/stop) with input and weight
// read addresses. It waits D_PIPE cycles for the MAC/bias/activation pipeline
// to drain and then issues one output write per valid lane of the group.
//
// Ports
//   clk       clock
//   xrst      synchronous reset, active-high
//   req       start-layer pulse, sampled only in IDLE
//   n_in      number of input neurons (non-zero)
//   n_out     number of output neurons (non-zero)
//   in_base   input memory base address
//   w_base    weight memory base address
//   out_base  output memory base address
//   ack       high while IDLE (ready / done)
//   out_ctrl  ctrl_bus toward the MAC pipeline: [2]=start [1]=valid [0]=stop
//   in_addr   input memory read address
//   w_addr    weight memory read address (one LANES-wide word per row)
//   out_we    output memory write enable
//   out_addr  output memory write address
//   out_lane  lane index selecting the result word for the current write
//
// Every output is a flop. Next-state values are computed first and the
// output flops are then loaded from those next-state values, so each output
// already reflects the state it is reported in without any combinational
// path from an input.
// -----------------------------------------------------------------------------
module gobou_ctrl_fc #(
    parameter  int LANES  = 16,
    parameter  int IN_W   = 12,
    parameter  int OUT_W  = 10,
    parameter  int W_W    = 16,
    parameter  int D_PIPE = 6,
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              req,
    input  logic [IN_W-1:0]   n_in,
    input  logic [OUT_W-1:0]  n_out,
    input  logic [IN_W-1:0]   in_base,
    input  logic [W_W-1:0]    w_base,
    input  logic [OUT_W-1:0]  out_base,
    output logic              ack,
    output logic [2:0]        out_ctrl,
    output logic [IN_W-1:0]   in_addr,
    output logic [W_W-1:0]    w_addr,
    output logic              out_we,
    output logic [OUT_W-1:0]  out_addr,
    output logic [LANE_W-1:0] out_lane
);

    localparam int DCNT_W = $clog2(D_PIPE + 1);

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        DRAIN,
        WRITE,
        DONE
    } state_e;

    // Sequencing state
    state_e              state_q,    state_d;
    logic [IN_W-1:0]     i_q,        i_d;
    logic [DCNT_W-1:0]   dcnt_q,     dcnt_d;
    logic [LANE_W-1:0]   k_q,        k_d;

    // Latched layer parameters, advanced once per group
    logic [IN_W-1:0]     n_in_q,     n_in_d;
    logic [IN_W-1:0]     in_base_q,  in_base_d;
    logic [W_W-1:0]      w_row_q,    w_row_d;    // w_base + group*n_in
    logic [OUT_W-1:0]    out_grp_q,  out_grp_d;  // out_base + group*LANES
    logic [OUT_W-1:0]    rem_q,      rem_d;      // n_out - group*LANES

    // Registered outputs
    logic                ack_q,      ack_d;
    logic [2:0]          out_ctrl_q, out_ctrl_d;
    logic [IN_W-1:0]     in_addr_q,  in_addr_d;
    logic [W_W-1:0]      w_addr_q,   w_addr_d;
    logic                out_we_q,   out_we_d;
    logic [OUT_W-1:0]    out_addr_q, out_addr_d;
    logic [LANE_W-1:0]   out_lane_q, out_lane_d;

    // Lane index of the last write in the current group: the group is full
    // unless fewer than LANES outputs remain.
    logic                full_grp;
    logic                more_grps;
    logic [LANE_W-1:0]   last_lane;

    assign full_grp  = (rem_q >= OUT_W'(LANES));
    assign more_grps = (rem_q >  OUT_W'(LANES));
    assign last_lane = full_grp ? LANE_W'(LANES - 1)
                                : (rem_q[LANE_W-1:0] - LANE_W'(1));

    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d    = state_q;
        i_d        = i_q;
        dcnt_d     = dcnt_q;
        k_d        = k_q;
        n_in_d     = n_in_q;
        in_base_d  = in_base_q;
        w_row_d    = w_row_q;
        out_grp_d  = out_grp_q;
        rem_d      = rem_q;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    n_in_d    = n_in;
                    in_base_d = in_base;
                    w_row_d   = w_base;
                    out_grp_d = out_base;
                    rem_d     = n_out;
                    i_d       = '0;
                    state_d   = MAC;
                end
            end
            MAC: begin
                if (i_q == n_in_q - IN_W'(1)) begin
                    dcnt_d  = '0;
                    state_d = DRAIN;
                end else begin
                    i_d = i_q + IN_W'(1);
                end
            end
            DRAIN: begin
                if (dcnt_q == DCNT_W'(D_PIPE - 1)) begin
                    k_d     = '0;
                    state_d = WRITE;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            WRITE: begin
                if (k_q == last_lane) begin
                    if (more_grps) begin
                        rem_d     = rem_q - OUT_W'(LANES);
                        w_row_d   = w_row_q + W_W'(n_in_q);
                        out_grp_d = out_grp_q + OUT_W'(LANES);
                        i_d       = '0;
                        state_d   = MAC;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    k_d = k_q + LANE_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs follow the state being entered; addresses hold their last
        // value outside the state that drives them.
        ack_d      = (state_d == IDLE);
        out_ctrl_d = 3'b000;
        in_addr_d  = in_addr_q;
        w_addr_d   = w_addr_q;
        out_we_d   = 1'b0;
        out_addr_d = out_addr_q;
        out_lane_d = out_lane_q;

        if (state_d == MAC) begin
            out_ctrl_d = {(i_d == '0), 1'b1, (i_d == n_in_d - IN_W'(1))};
            in_addr_d  = in_base_d + i_d;
            w_addr_d   = w_row_d + W_W'(i_d);
        end
        if (state_d == WRITE) begin
            out_we_d   = 1'b1;
            out_lane_d = k_d;
            out_addr_d = out_grp_d + OUT_W'(k_d);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge value of every other flop.
        if (xrst) begin
            state_q    <= IDLE;
            i_q        <= '0;
            dcnt_q     <= '0;
            k_q        <= '0;
            n_in_q     <= '0;
            in_base_q  <= '0;
            w_row_q    <= '0;
            out_grp_q  <= '0;
            rem_q      <= '0;
            ack_q      <= 1'b1;
            out_ctrl_q <= 3'b000;
            in_addr_q  <= '0;
            w_addr_q   <= '0;
            out_we_q   <= 1'b0;
            out_addr_q <= '0;
            out_lane_q <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            dcnt_q     <= dcnt_d;
            k_q        <= k_d;
            n_in_q     <= n_in_d;
            in_base_q  <= in_base_d;
            w_row_q    <= w_row_d;
            out_grp_q  <= out_grp_d;
            rem_q      <= rem_d;
            ack_q      <= ack_d;
            out_ctrl_q <= out_ctrl_d;
            in_addr_q  <= in_addr_d;
            w_addr_q   <= w_addr_d;
            out_we_q   <= out_we_d;
            out_addr_q <= out_addr_d;
            out_lane_q <= out_lane_d;
        end
    end

    assign ack      = ack_q;
    assign out_ctrl = out_ctrl_q;
    assign in_addr  = in_addr_q;
    assign w_addr   = w_addr_q;
    assign out_we   = out_we_q;
    assign out_addr = out_addr_q;
    assign out_lane = out_lane_q;

endmodule
